mc_ctrl: RTL and testbench

Multi-cycle main controller for the MIPS datapath. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives every datapath select and write-enable, including the `RegDst`, `ALUSrc` and `DataSrc` selects consumed by the write-back/operand muxes. It sits between the IR (opcode/funct) and the datapath and replaces per-instruction combinational control with a state machine.

---
 rtl/mc_ctrl_pkg.sv | 105 ++++++++++
 rtl/mc_decode.sv | 35 +++
 rtl/mc_ctrl.sv | 149 ++++++++++++++
 tb/tb_mc_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main controller: select/op codes,
// opcode/funct constants, controller states and the decoded instruction class.
package mc_ctrl_pkg;

  localparam logic [1:0] RegDst_A3   = 2'd0;
  localparam logic [1:0] RegDst_A2   = 2'd1;
  localparam logic [1:0] RegDst_ra   = 2'd2;

  localparam logic [1:0] DataSrc_alu = 2'd0;
  localparam logic [1:0] DataSrc_dm  = 2'd1;
  localparam logic [1:0] DataSrc_ifu = 2'd2;

  localparam logic [1:0] NPC_PC4     = 2'd0;
  localparam logic [1:0] NPC_BRANCH  = 2'd1;
  localparam logic [1:0] NPC_JUMP    = 2'd2;
  localparam logic [1:0] NPC_JR      = 2'd3;

  localparam logic [1:0] EXT_ZERO    = 2'd0;
  localparam logic [1:0] EXT_SIGN    = 2'd1;
  localparam logic [1:0] EXT_LUI     = 2'd2;

  localparam logic [2:0] ALU_ADD     = 3'd0;
  localparam logic [2:0] ALU_SUB     = 3'd1;
  localparam logic [2:0] ALU_OR      = 3'd2;

  localparam logic [5:0] OP_RTYPE    = 6'h00;
  localparam logic [5:0] OP_J        = 6'h02;
  localparam logic [5:0] OP_JAL      = 6'h03;
  localparam logic [5:0] OP_BEQ      = 6'h04;
  localparam logic [5:0] OP_ORI      = 6'h0d;
  localparam logic [5:0] OP_LUI      = 6'h0f;
  localparam logic [5:0] OP_LW       = 6'h23;
  localparam logic [5:0] OP_SW       = 6'h2b;

  localparam logic [5:0] FN_JR       = 6'h08;
  localparam logic [5:0] FN_ADDU     = 6'h21;
  localparam logic [5:0] FN_SUBU     = 6'h23;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    C_NOP  = 4'd0,
    C_ADDU = 4'd1,
    C_SUBU = 4'd2,
    C_JR   = 4'd3,
    C_ORI  = 4'd4,
    C_LUI  = 4'd5,
    C_LW   = 4'd6,
    C_SW   = 4'd7,
    C_BEQ  = 4'd8,
    C_J    = 4'd9,
    C_JAL  = 4'd10
  } cls_t;

  typedef struct packed {
    logic       pc_wr;
    logic       ir_wr;
    logic [1:0] npc_op;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic       alu_src;
    logic [1:0] ext_op;
    logic [2:0] alu_op;
    logic       mem_write;
    logic [1:0] data_src;
    logic       instr_done;
  } ctrl_t;

  // ALU operand/operation setup for a class; reused in EXEC, MEM and WB so the
  // registered ALU result is computed from the same controls throughout.
  function automatic ctrl_t alu_ctrl(input cls_t c);
    ctrl_t r;
    r = '0;
    case (c)
      C_ADDU: r.alu_op = ALU_ADD;
      C_SUBU,
      C_BEQ:  r.alu_op = ALU_SUB;
      C_ORI: begin
        r.alu_op  = ALU_OR;
        r.alu_src = 1'b1;
        r.ext_op  = EXT_ZERO;
      end
      C_LUI: begin
        r.alu_op  = ALU_OR;
        r.alu_src = 1'b1;
        r.ext_op  = EXT_LUI;
      end
      C_LW,
      C_SW: begin
        r.alu_op  = ALU_ADD;
        r.alu_src = 1'b1;
        r.ext_op  = EXT_SIGN;
      end
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: opcode/funct -> instruction class.
// Unrecognised encodings, including the all-zero nop, map to C_NOP.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output cls_t       cls
);

  // NOTE: assigning a default before the case keeps this purely combinational;
  // a path that leaves cls unassigned would infer a latch.
  always_comb begin
    cls = C_NOP;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: cls = C_ADDU;
          FN_SUBU: cls = C_SUBU;
          FN_JR:   cls = C_JR;
          default: cls = C_NOP;
        endcase
      end
      OP_ORI:  cls = C_ORI;
      OP_LUI:  cls = C_LUI;
      OP_LW:   cls = C_LW;
      OP_SW:   cls = C_SW;
      OP_BEQ:  cls = C_BEQ;
      OP_J:    cls = C_J;
      OP_JAL:  cls = C_JAL;
      default: cls = C_NOP;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller: sequences FETCH/DECODE/EXEC/MEM/WB and drives
// every datapath select and write enable from state plus the latched class.
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       PCWr,
  output logic       IRWr,
  output logic [1:0] NPCOp,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic       ALUSrc,
  output logic [1:0] ExtOp,
  output logic [2:0] ALUOp,
  output logic       MemWrite,
  output logic [1:0] DataSrc,
  output logic       InstrDone
);

  state_t state, next_state;
  cls_t   dec_cls, cls_q;
  ctrl_t  ctrl;

  mc_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .cls    (dec_cls)
  );

  // NOTE: state is updated with non-blocking assignments so every register
  // samples its inputs from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      cls_q <= C_NOP;
    end else begin
      state <= next_state;
      if (state == S_DECODE) cls_q <= dec_cls;
    end
  end

  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        case (dec_cls)
          C_J, C_JR, C_NOP: next_state = S_FETCH;
          C_JAL:            next_state = S_WB;
          default:          next_state = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (cls_q)
          C_BEQ:      next_state = S_FETCH;
          C_LW, C_SW: next_state = S_MEM;
          default:    next_state = S_WB;
        endcase
      end
      S_MEM:    next_state = (cls_q == C_LW) ? S_WB : S_FETCH;
      S_WB:     next_state = S_FETCH;
      default:  next_state = S_FETCH;
    endcase
  end

  // DECODE steers jumps from the live class since the class register is only
  // being loaded at the end of that cycle; later states use cls_q exclusively.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.ir_wr  = 1'b1;
        ctrl.pc_wr  = 1'b1;
        ctrl.npc_op = NPC_PC4;
      end
      S_DECODE: begin
        case (dec_cls)
          C_J, C_JAL: begin
            ctrl.pc_wr  = 1'b1;
            ctrl.npc_op = NPC_JUMP;
          end
          C_JR: begin
            ctrl.pc_wr  = 1'b1;
            ctrl.npc_op = NPC_JR;
          end
          default: ;
        endcase
        ctrl.instr_done = (dec_cls == C_J) || (dec_cls == C_JR) || (dec_cls == C_NOP);
      end
      S_EXEC: begin
        ctrl = alu_ctrl(cls_q);
        if (cls_q == C_BEQ) begin
          ctrl.pc_wr      = zero;
          ctrl.npc_op     = NPC_BRANCH;
          ctrl.instr_done = 1'b1;
        end
      end
      S_MEM: begin
        ctrl = alu_ctrl(cls_q);
        if (cls_q == C_SW) begin
          ctrl.mem_write  = 1'b1;
          ctrl.instr_done = 1'b1;
        end
      end
      S_WB: begin
        ctrl            = alu_ctrl(cls_q);
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
        case (cls_q)
          C_ORI, C_LUI: begin
            ctrl.reg_dst  = RegDst_A2;
            ctrl.data_src = DataSrc_alu;
          end
          C_LW: begin
            ctrl.reg_dst  = RegDst_A2;
            ctrl.data_src = DataSrc_dm;
          end
          C_JAL: begin
            ctrl.reg_dst  = RegDst_ra;
            ctrl.data_src = DataSrc_ifu;
          end
          default: begin
            ctrl.reg_dst  = RegDst_A3;
            ctrl.data_src = DataSrc_alu;
          end
        endcase
      end
      default: ;
    endcase
    if (reset) ctrl = '0;
  end

  assign PCWr      = ctrl.pc_wr;
  assign IRWr      = ctrl.ir_wr;
  assign NPCOp     = ctrl.npc_op;
  assign RegWrite  = ctrl.reg_write;
  assign RegDst    = ctrl.reg_dst;
  assign ALUSrc    = ctrl.alu_src;
  assign ExtOp     = ctrl.ext_op;
  assign ALUOp     = ctrl.alu_op;
  assign MemWrite  = ctrl.mem_write;
  assign DataSrc   = ctrl.data_src;
  assign InstrDone = ctrl.instr_done;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed scenarios plus random instruction
// streams compared cycle by cycle against a per-instruction timeline model.
module tb_mc_ctrl;
  import mc_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       PCWr, IRWr, RegWrite, ALUSrc, MemWrite, InstrDone;
  logic [1:0] NPCOp, RegDst, ExtOp, DataSrc;
  logic [2:0] ALUOp;
  logic [16:0] obs;

  int checks = 0;
  int errors = 0;

  typedef enum {K_NOP, K_ADDU, K_SUBU, K_JR, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_J, K_JAL} kind_t;

  mc_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .funct     (funct),
    .zero      (zero),
    .PCWr      (PCWr),
    .IRWr      (IRWr),
    .NPCOp     (NPCOp),
    .RegWrite  (RegWrite),
    .RegDst    (RegDst),
    .ALUSrc    (ALUSrc),
    .ExtOp     (ExtOp),
    .ALUOp     (ALUOp),
    .MemWrite  (MemWrite),
    .DataSrc   (DataSrc),
    .InstrDone (InstrDone)
  );

  always #5 clk = ~clk;

  assign obs = {PCWr, IRWr, NPCOp, RegWrite, RegDst, ALUSrc, ExtOp, ALUOp,
                MemWrite, DataSrc, InstrDone};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: return (fn == 6'h21) ? K_ADDU : (fn == 6'h23) ? K_SUBU :
                    (fn == 6'h08) ? K_JR : K_NOP;
      6'h0d: return K_ORI;
      6'h0f: return K_LUI;
      6'h23: return K_LW;
      6'h2b: return K_SW;
      6'h04: return K_BEQ;
      6'h02: return K_J;
      6'h03: return K_JAL;
      default: return K_NOP;
    endcase
  endfunction

  function automatic logic [16:0] pack(input logic pcwr, input logic irwr, input logic [1:0] npc,
                                       input logic rw, input logic [1:0] rd, input logic asrc,
                                       input logic [1:0] ext, input logic [2:0] aop,
                                       input logic mw, input logic [1:0] ds, input logic done);
    return {pcwr, irwr, npc, rw, rd, asrc, ext, aop, mw, ds, done};
  endfunction

  // Runs one instruction from its FETCH cycle. If abort_at indexes a cycle of
  // the instruction, reset is raised in that cycle and the instruction ends.
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int abort_at);
    kind_t k;
    logic [16:0] exp[$];
    logic as;
    logic [1:0] ex;
    logic [2:0] ao;
    logic [16:0] e;
    k = classify(op, fn);
    as = 1'b0; ex = 2'd0; ao = 3'd0;
    case (k)
      K_ADDU: ao = 3'd0;
      K_SUBU, K_BEQ: ao = 3'd1;
      K_ORI: begin ao = 3'd2; as = 1'b1; ex = 2'd0; end
      K_LUI: begin ao = 3'd2; as = 1'b1; ex = 2'd2; end
      K_LW, K_SW: begin ao = 3'd0; as = 1'b1; ex = 2'd1; end
      default: ;
    endcase

    exp.push_back(pack(1, 1, 2'd0, 0, 2'd0, 0, 2'd0, 3'd0, 0, 2'd0, 0));
    case (k)
      K_J, K_JAL: exp.push_back(pack(1, 0, 2'd2, 0, 2'd0, 0, 2'd0, 3'd0, 0, 2'd0, k == K_J));
      K_JR:       exp.push_back(pack(1, 0, 2'd3, 0, 2'd0, 0, 2'd0, 3'd0, 0, 2'd0, 1));
      K_NOP:      exp.push_back(pack(0, 0, 2'd0, 0, 2'd0, 0, 2'd0, 3'd0, 0, 2'd0, 1));
      default:    exp.push_back(pack(0, 0, 2'd0, 0, 2'd0, 0, 2'd0, 3'd0, 0, 2'd0, 0));
    endcase
    if (k == K_JAL) begin
      exp.push_back(pack(0, 0, 2'd0, 1, RegDst_ra, 0, 2'd0, 3'd0, 0, DataSrc_ifu, 1));
    end else if (k != K_J && k != K_JR && k != K_NOP) begin
      if (k == K_BEQ)
        exp.push_back(pack(z, 0, 2'd1, 0, 2'd0, as, ex, ao, 0, 2'd0, 1));
      else
        exp.push_back(pack(0, 0, 2'd0, 0, 2'd0, as, ex, ao, 0, 2'd0, 0));
      if (k == K_SW)
        exp.push_back(pack(0, 0, 2'd0, 0, 2'd0, as, ex, ao, 1, 2'd0, 1));
      if (k == K_LW) begin
        exp.push_back(pack(0, 0, 2'd0, 0, 2'd0, as, ex, ao, 0, 2'd0, 0));
        exp.push_back(pack(0, 0, 2'd0, 1, RegDst_A2, as, ex, ao, 0, DataSrc_dm, 1));
      end
      if (k == K_ADDU || k == K_SUBU)
        exp.push_back(pack(0, 0, 2'd0, 1, RegDst_A3, as, ex, ao, 0, DataSrc_alu, 1));
      if (k == K_ORI || k == K_LUI)
        exp.push_back(pack(0, 0, 2'd0, 1, RegDst_A2, as, ex, ao, 0, DataSrc_alu, 1));
    end

    opcode = op;
    funct  = fn;
    zero   = z;
    for (int c = 0; c < exp.size(); c++) begin
      e = exp[c];
      if (c == abort_at) begin
        reset = 1'b1;
        e = '0;
      end
      @(negedge clk);
      check($sformatf("%s_c%0d", name, c), 32'(obs), 32'(e));
      if (c == abort_at) check($sformatf("%s_rst_memwrite", name), 32'(MemWrite), 32'd0);
      @(posedge clk);
      #1;
      if (c == abort_at) begin
        reset = 1'b0;
        break;
      end
      if (c == 1) begin
        opcode = 6'($urandom);
        funct  = 6'($urandom);
      end
    end
  endtask

  logic [5:0] pool_op [12] = '{6'h00, 6'h00, 6'h00, 6'h0d, 6'h0f, 6'h23,
                               6'h2b, 6'h04, 6'h02, 6'h03, 6'h3f, 6'h00};
  logic [5:0] pool_fn [12] = '{6'h21, 6'h23, 6'h08, 6'h00, 6'h00, 6'h00,
                               6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h20};

  initial begin
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("reset_c%0d", i), 32'(obs), 32'd0);
      @(posedge clk);
    end
    #1;
    reset = 1'b0;

    run_instr("addu",   6'h00, 6'h21, 1'b0, -1);
    run_instr("lw",     6'h23, 6'h15, 1'b0, -1);
    run_instr("beq_z1", 6'h04, 6'h00, 1'b1, -1);
    run_instr("beq_z0", 6'h04, 6'h00, 1'b0, -1);
    run_instr("jal",    6'h03, 6'h00, 1'b0, -1);
    run_instr("sw_rst", 6'h2b, 6'h00, 1'b0, 3);
    run_instr("ill3f",  6'h3f, 6'h00, 1'b0, -1);
    run_instr("nop",    6'h00, 6'h00, 1'b1, -1);

    for (int n = 0; n < 80; n++) begin
      int idx;
      logic [5:0] fn;
      int ab;
      idx = $urandom_range(0, 11);
      fn  = pool_fn[idx];
      if (pool_op[idx] != 6'h00) fn = 6'($urandom);
      ab  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 4) : -1;
      run_instr($sformatf("rnd%0d", n), pool_op[idx], fn, 1'($urandom), ab);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
